axi4lite_ram_slave: RTL and testbench
=====================================

# axi4lite_ram_slave

AXI4-lite slave endpoint holding a byte-strobed, word-organised RAM, attached to one slave port of `axi4_interconnect`. It consumes the interconnect's `s_axi_*` channel set, with no BRESP/RRESP, exactly as the interconnect drives it. Read and write paths are independent FSMs sharing one RAM. It serves as the boot/data memory behind the interconnect's low address window.

## Interface
- `sword`, 32: data/address word width.
- `depth`, 256: RAM depth in words, power of two, at least 2.
- `CLK`  in  1: single clock, rising edge.
- `RST`  in  1: synchronous reset, active-low.
- `s_axi_awvalid` in 1 / `s_axi_awready` out 1 / `s_axi_awaddr` in sword / `s_axi_awprot` in 3
- `s_axi_wvalid` in 1 / `s_axi_wready` out 1 / `s_axi_wdata` in sword / `s_axi_wstrb` in sword/8
- `s_axi_bvalid` out 1 / `s_axi_bready` in 1
- `s_axi_arvalid` in 1 / `s_axi_arready` out 1 / `s_axi_araddr` in sword / `s_axi_arprot` in 3
- `s_axi_rvalid` out 1 / `s_axi_rready` in 1 / `s_axi_rdata` out sword

## Operation
- Word index is `addr[clogb2(depth)+1:2]`. Upper bits and `addr[1:0]` are ignored, so the RAM aliases (wraps) every `depth*4` bytes.
- Write FSM states: W_IDLE, W_GOTA (address held, awaiting data), W_GOTD (data and strobe held, awaiting address), W_RESP.
  - W_IDLE: AW handshake only → W_GOTA. W handshake only → W_GOTD. Both in the same cycle → W_RESP.
  - W_GOTA + W handshake → W_RESP. W_GOTD + AW handshake → W_RESP.
  - On entry to W_RESP, the RAM is written with the held/incoming data, byte lane `i` only where `wstrb[i]` is set. `wstrb` of 0 writes nothing but still responds.
  - W_RESP: `bvalid`=1 until `bready` is seen → W_IDLE.
- `awready`=1 in W_IDLE and W_GOTD only. `wready`=1 in W_IDLE and W_GOTA only. Both are registered.
- Read FSM states: R_IDLE (`arready`=1), R_FETCH (RAM read cycle), R_DATA (`rvalid`=1, `rdata` stable).
  - AR handshake → R_FETCH → R_DATA.
  - `rready` in R_DATA → R_IDLE.
- Simultaneous RAM write and RAM read of the same word: the read returns the old data (read-before-write).
- Only one outstanding transaction per direction. A new AW/W/AR is not accepted until the previous B/R handshake completes.

## Timing
- Reset (`RST`=0 at a rising edge): both FSMs go idle. `bvalid`=0, `rvalid`=0, `rdata`=0. `awready`=`wready`=`arready`=1 from the first cycle after reset is released. RAM contents are not cleared.
- Reset mid-transaction aborts it. A pending write that has not reached W_RESP is not committed.
- Write latency: `bvalid` rises the cycle after the last of the AW/W handshakes. Minimum AW → B is 1 cycle.
- Read latency: `rvalid` rises 2 cycles after the AR handshake.
- Once asserted, `bvalid`/`rvalid` stay high and `rdata` stays stable until the matching ready is sampled high.
- Throughput: one write per 2 cycles and one read per 3 cycles, each at best case.

## Configuration
- `AXI4LITE_RAM_PROT_EN` defined: accesses with `prot[0]`=0 (unprivileged) are handled as follows.
  - Writes are dropped: no RAM update, but B still completes normally.
  - Reads return 0 with normal R timing.
- `AXI4LITE_RAM_PROT_EN` undefined: `awprot`/`arprot` are ignored and all accesses are serviced.

## Structure
- Shared package `axi4lite_pkg`:
  - write and read FSM state enums;
  - `clogb2` function;
  - `AXI_STRB_W = sword/8` constant.
- Sub-module `axi4lite_ram_core`: single-clock RAM, one write port with byte enables and one synchronous read port, read-before-write. The FSMs stay in the top.

## Test plan
1. Reset, then check outputs: `bvalid`=`rvalid`=0, `rdata`=0, and all three readies = 1 one cycle after `RST` rises.
2. AW (0x0000_0010) and W (0xDEAD_BEEF, strb 0xF) in the same cycle, `bready`=1 → `bvalid` high exactly 1 cycle later for 1 cycle. Read of 0x10 → `rvalid` 2 cycles after AR, `rdata`=0xDEAD_BEEF.
3. W first (0x1122_3344, strb 0x5), AW to 0x10 three cycles later → `awready` stays 1 and `wready`=0 while waiting. Readback = 0xDE22_BE44.
4. Hold `rready`=0 for 5 cycles after `rvalid` rises → `rvalid` and `rdata` stay stable and `arready`=0 throughout. Same for `bready`=0 with `bvalid`.
5. Write 0xA5A5_A5A5 to 0x0 then read 0x400 (`depth`=256) → 0xA5A5_A5A5 (alias). Write and read of the same word committed in the same cycle → old value returned.
6. Assert `RST`=0 while in W_GOTA, then write data → no RAM change at that address, B not issued. With `AXI4LITE_RAM_PROT_EN` defined, a write with `awprot`=0 leaves the RAM unchanged and a read with `arprot`=0 returns 0.

Source files
------------

// File: rtl/axi4lite_pkg.sv
// Shared types and helpers for the AXI4-lite RAM slave.
// Optional feature macro used by the slave: AXI4LITE_RAM_PROT_EN.
package axi4lite_pkg;

    localparam int AXI_SWORD  = 32;
    localparam int AXI_STRB_W = AXI_SWORD / 8;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_GOTA = 2'd1,
        W_GOTD = 2'd2,
        W_RESP = 2'd3
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } r_state_t;

    // Ceiling log2, used to size the word index.
    function automatic int clogb2(input int n);
        int r;
        for (r = 0; (1 << r) < n; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/axi4lite_ram_core.sv
// Single-clock word RAM: byte-enabled write port, registered read port.
// A read and a write of the same word at one edge return the old data.
module axi4lite_ram_core
    import axi4lite_pkg::*;
#(
    parameter int DW     = AXI_SWORD,
    parameter int DEPTH  = 256,
    parameter int AW     = 8,
    parameter int STRB_W = AXI_STRB_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DW-1:0]     wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DW-1:0]     rdout
);

    logic [DW-1:0] mem [DEPTH];

    // Byte-lane write; contents are never cleared by reset.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < STRB_W; i++) begin
            if (we && wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
    end

    // Read register holds its value until the next read strobe.
    always_ff @(posedge CLK) begin
        if (!RST)    rdout <= '0;
        else if (re) rdout <= mem[raddr];
    end

endmodule

// File: rtl/axi4lite_ram_slave.sv
// AXI4-lite slave with an internal byte-strobed RAM; independent write and
// read FSMs, one outstanding transaction per direction.
// Optional: AXI4LITE_RAM_PROT_EN drops unprivileged writes and zeroes
// unprivileged reads.
module axi4lite_ram_slave
    import axi4lite_pkg::*;
#(
    parameter int sword = AXI_SWORD,
    parameter int depth = 256
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               s_axi_awvalid,
    output logic               s_axi_awready,
    input  logic [sword-1:0]   s_axi_awaddr,
    input  logic [2:0]         s_axi_awprot,
    input  logic               s_axi_wvalid,
    output logic               s_axi_wready,
    input  logic [sword-1:0]   s_axi_wdata,
    input  logic [sword/8-1:0] s_axi_wstrb,
    output logic               s_axi_bvalid,
    input  logic               s_axi_bready,
    input  logic               s_axi_arvalid,
    output logic               s_axi_arready,
    input  logic [sword-1:0]   s_axi_araddr,
    input  logic [2:0]         s_axi_arprot,
    output logic               s_axi_rvalid,
    input  logic               s_axi_rready,
    output logic [sword-1:0]   s_axi_rdata
);

    localparam int AW = clogb2(depth);

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [AW-1:0]      aw_idx_q, ar_idx_q;
    logic [sword-1:0]   w_data_q;
    logic [sword/8-1:0] w_strb_q;
    logic               aw_hs, w_hs, ar_hs;

    logic               ram_we, ram_re;
    logic [AW-1:0]      ram_waddr;
    logic [sword-1:0]   ram_wdata, ram_dout;
    logic [sword/8-1:0] ram_wstrb;
    logic               w_priv;

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid  && s_axi_wready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;

    // Write FSM state register.
    always_ff @(posedge CLK) begin
        if (!RST) w_state <= W_IDLE;
        else      w_state <= w_next;
    end

    // Write FSM next state and channel flags.
    always_comb begin
        w_next        = w_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                s_axi_awready = 1'b1;
                s_axi_wready  = 1'b1;
                if (aw_hs && w_hs) w_next = W_RESP;
                else if (aw_hs)    w_next = W_GOTA;
                else if (w_hs)     w_next = W_GOTD;
            end
            W_GOTA: begin
                s_axi_wready = 1'b1;
                if (w_hs) w_next = W_RESP;
            end
            W_GOTD: begin
                s_axi_awready = 1'b1;
                if (aw_hs) w_next = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Hold whichever half of the write arrived first.
    always_ff @(posedge CLK) begin
        if (aw_hs) aw_idx_q <= s_axi_awaddr[AW+1:2];
        if (w_hs) begin
            w_data_q <= s_axi_wdata;
            w_strb_q <= s_axi_wstrb;
        end
    end

`ifdef AXI4LITE_RAM_PROT_EN
    logic aw_priv_q;

    // Privilege bit travels with the held address.
    always_ff @(posedge CLK) begin
        if (aw_hs) aw_priv_q <= s_axi_awprot[0];
    end

    assign w_priv = (w_state == W_GOTA) ? aw_priv_q : s_axi_awprot[0];
`else
    assign w_priv = 1'b1;
`endif

    // Commit on the edge that enters W_RESP; reset at that edge aborts it.
    assign ram_we    = RST && w_priv && (w_state != W_RESP) && (w_next == W_RESP);
    assign ram_waddr = (w_state == W_GOTA) ? aw_idx_q : s_axi_awaddr[AW+1:2];
    assign ram_wdata = (w_state == W_GOTD) ? w_data_q : s_axi_wdata;
    assign ram_wstrb = (w_state == W_GOTD) ? w_strb_q : s_axi_wstrb;

    // Read FSM state register.
    always_ff @(posedge CLK) begin
        if (!RST) r_state <= R_IDLE;
        else      r_state <= r_next;
    end

    // Read FSM next state and channel flags.
    always_comb begin
        r_next        = r_state;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        ram_re        = 1'b0;
        case (r_state)
            R_IDLE: begin
                s_axi_arready = 1'b1;
                if (ar_hs) r_next = R_FETCH;
            end
            R_FETCH: begin
                ram_re = 1'b1;
                r_next = R_DATA;
            end
            R_DATA: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Latch the read word index at the AR handshake.
    always_ff @(posedge CLK) begin
        if (ar_hs) ar_idx_q <= s_axi_araddr[AW+1:2];
    end

`ifdef AXI4LITE_RAM_PROT_EN
    logic rd_blk_q;

    // Unprivileged reads still take the normal path but present zero.
    always_ff @(posedge CLK) begin
        if (!RST)       rd_blk_q <= 1'b0;
        else if (ar_hs) rd_blk_q <= !s_axi_arprot[0];
    end

    assign s_axi_rdata = rd_blk_q ? '0 : ram_dout;
`else
    assign s_axi_rdata = ram_dout;
`endif

    axi4lite_ram_core #(
        .DW     (sword),
        .DEPTH  (depth),
        .AW     (AW),
        .STRB_W (sword/8)
    ) u_ram (
        .CLK   (CLK),
        .RST   (RST),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .wstrb (ram_wstrb),
        .re    (ram_re),
        .raddr (ar_idx_q),
        .rdout (ram_dout)
    );

    // Address bits outside the word index alias; prot is only partly used.
    logic unused_bits;
`ifdef AXI4LITE_RAM_PROT_EN
    assign unused_bits = ^{s_axi_awaddr[sword-1:AW+2], s_axi_awaddr[1:0],
                           s_axi_araddr[sword-1:AW+2], s_axi_araddr[1:0],
                           s_axi_awprot[2:1], s_axi_arprot[2:1]};
`else
    assign unused_bits = ^{s_axi_awaddr[sword-1:AW+2], s_axi_awaddr[1:0],
                           s_axi_araddr[sword-1:AW+2], s_axi_araddr[1:0],
                           s_axi_awprot, s_axi_arprot};
`endif

endmodule

// File: tb/tb_axi4lite_ram_slave.sv
// Directed bench for axi4lite_ram_slave; inputs driven and outputs sampled
// on the falling edge.
module tb_axi4lite_ram_slave;

    logic        CLK = 1'b0;
    logic        RST;
    logic        s_axi_awvalid, s_axi_awready;
    logic [31:0] s_axi_awaddr;
    logic [2:0]  s_axi_awprot;
    logic        s_axi_wvalid, s_axi_wready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_bvalid, s_axi_bready;
    logic        s_axi_arvalid, s_axi_arready;
    logic [31:0] s_axi_araddr;
    logic [2:0]  s_axi_arprot;
    logic        s_axi_rvalid, s_axi_rready;
    logic [31:0] s_axi_rdata;

    int errs   = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    axi4lite_ram_slave #(.sword(32), .depth(256)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awprot  (s_axi_awprot),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arprot  (s_axi_arprot),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .s_axi_rdata   (s_axi_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    // AW and W together, bready high: B for exactly one cycle.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [2:0] prot, input string tag);
        s_axi_awvalid = 1'b1; s_axi_awaddr = a; s_axi_awprot = prot;
        s_axi_wvalid  = 1'b1; s_axi_wdata  = d; s_axi_wstrb  = s;
        s_axi_bready  = 1'b1;
        @(negedge CLK);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        chk({tag, ".bvalid1"}, 32'(s_axi_bvalid), 32'd1);
        @(negedge CLK);
        chk({tag, ".bvalid0"}, 32'(s_axi_bvalid), 32'd0);
    endtask

    // Read with rready asserted as soon as rvalid rises.
    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input logic [2:0] prot,
                      input string tag);
        s_axi_arvalid = 1'b1; s_axi_araddr = a; s_axi_arprot = prot;
        s_axi_rready  = 1'b0;
        @(negedge CLK);
        s_axi_arvalid = 1'b0;
        chk({tag, ".rvalid_fetch"}, 32'(s_axi_rvalid), 32'd0);
        @(negedge CLK);
        chk({tag, ".rvalid"}, 32'(s_axi_rvalid), 32'd1);
        chk({tag, ".rdata"}, s_axi_rdata, exp);
        s_axi_rready = 1'b1;
        @(negedge CLK);
        s_axi_rready = 1'b0;
        chk({tag, ".rvalid_done"}, 32'(s_axi_rvalid), 32'd0);
    endtask

    initial begin
        RST = 1'b0;
        s_axi_awvalid = 1'b0; s_axi_awaddr = '0; s_axi_awprot = 3'b001;
        s_axi_wvalid  = 1'b0; s_axi_wdata  = '0; s_axi_wstrb  = '0;
        s_axi_bready  = 1'b0;
        s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_arprot = 3'b001;
        s_axi_rready  = 1'b0;

        // 1: reset state
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("rst.bvalid",  32'(s_axi_bvalid),  32'd0);
        chk("rst.rvalid",  32'(s_axi_rvalid),  32'd0);
        chk("rst.rdata",   s_axi_rdata,        32'd0);
        chk("rst.awready", 32'(s_axi_awready), 32'd1);
        chk("rst.wready",  32'(s_axi_wready),  32'd1);
        chk("rst.arready", 32'(s_axi_arready), 32'd1);

        // 2: same-cycle AW+W, then readback
        wr(32'h10, 32'hDEAD_BEEF, 4'hF, 3'b001, "w_both");
        rd(32'h10, 32'hDEAD_BEEF, 3'b001, "r_both");

        // 3: W first, AW three cycles later
        s_axi_wvalid = 1'b1; s_axi_wdata = 32'h1122_3344; s_axi_wstrb = 4'h5;
        s_axi_bready = 1'b1;
        @(negedge CLK);
        s_axi_wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("wfirst.wready",  32'(s_axi_wready),  32'd0);
            chk("wfirst.awready", 32'(s_axi_awready), 32'd1);
            chk("wfirst.bvalid",  32'(s_axi_bvalid),  32'd0);
            if (i < 2) @(negedge CLK);
        end
        s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h10; s_axi_awprot = 3'b001;
        @(negedge CLK);
        s_axi_awvalid = 1'b0;
        chk("wfirst.bvalid1", 32'(s_axi_bvalid), 32'd1);
        @(negedge CLK);
        chk("wfirst.bvalid0", 32'(s_axi_bvalid), 32'd0);
        rd(32'h10, 32'hDE22_BE44, 3'b001, "r_strb");

        // 4: backpressure on R
        s_axi_arvalid = 1'b1; s_axi_araddr = 32'h10; s_axi_rready = 1'b0;
        @(negedge CLK);
        s_axi_arvalid = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < 5; i++) begin
            chk("rhold.rvalid",  32'(s_axi_rvalid),  32'd1);
            chk("rhold.rdata",   s_axi_rdata,        32'hDE22_BE44);
            chk("rhold.arready", 32'(s_axi_arready), 32'd0);
            @(negedge CLK);
        end
        s_axi_rready = 1'b1;
        @(negedge CLK);
        s_axi_rready = 1'b0;
        chk("rhold.rvalid0",  32'(s_axi_rvalid),  32'd0);
        chk("rhold.arready1", 32'(s_axi_arready), 32'd1);

        // 4: backpressure on B (also the alias pattern for 5)
        s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h0;
        s_axi_wvalid  = 1'b1; s_axi_wdata  = 32'hA5A5_A5A5; s_axi_wstrb = 4'hF;
        s_axi_bready  = 1'b0;
        @(negedge CLK);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bhold.bvalid",  32'(s_axi_bvalid),  32'd1);
            chk("bhold.awready", 32'(s_axi_awready), 32'd0);
            chk("bhold.wready",  32'(s_axi_wready),  32'd0);
            @(negedge CLK);
        end
        s_axi_bready = 1'b1;
        @(negedge CLK);
        chk("bhold.bvalid0", 32'(s_axi_bvalid), 32'd0);

        // 5: aliasing and read-before-write
        rd(32'h400, 32'hA5A5_A5A5, 3'b001, "alias400");
        rd(32'h803, 32'hA5A5_A5A5, 3'b001, "alias803");
        wr(32'h20, 32'h0123_4567, 4'hF, 3'b001, "w_pre20");
        s_axi_arvalid = 1'b1; s_axi_araddr = 32'h20;
        @(negedge CLK);
        s_axi_arvalid = 1'b0;
        s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h20;
        s_axi_wvalid  = 1'b1; s_axi_wdata  = 32'h89AB_CDEF; s_axi_wstrb = 4'hF;
        @(negedge CLK);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        chk("rbw.rvalid", 32'(s_axi_rvalid), 32'd1);
        chk("rbw.rdata",  s_axi_rdata,       32'h0123_4567);
        chk("rbw.bvalid", 32'(s_axi_bvalid), 32'd1);
        s_axi_rready = 1'b1;
        @(negedge CLK);
        s_axi_rready = 1'b0;
        rd(32'h20, 32'h89AB_CDEF, 3'b001, "rbw_after");

        // zero strobe: responds, writes nothing
        wr(32'h30, 32'h5566_7788, 4'hF, 3'b001, "w_pre30");
        wr(32'h30, 32'h0000_0000, 4'h0, 3'b001, "w_strb0");
        rd(32'h30, 32'h5566_7788, 3'b001, "r_strb0");

        // 6: reset while holding an address aborts the write
        s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h30;
        @(negedge CLK);
        s_axi_awvalid = 1'b0;
        chk("gota.awready", 32'(s_axi_awready), 32'd0);
        chk("gota.wready",  32'(s_axi_wready),  32'd1);
        RST = 1'b0;
        s_axi_wvalid = 1'b1; s_axi_wdata = 32'hFFFF_FFFF; s_axi_wstrb = 4'hF;
        @(negedge CLK);
        RST = 1'b1; s_axi_wvalid = 1'b0;
        chk("abort.bvalid", 32'(s_axi_bvalid), 32'd0);
        @(negedge CLK);
        chk("abort.bvalid2",  32'(s_axi_bvalid),  32'd0);
        chk("abort.awready",  32'(s_axi_awready), 32'd1);
        rd(32'h30, 32'h5566_7788, 3'b001, "r_abort");

`ifdef AXI4LITE_RAM_PROT_EN
        wr(32'h30, 32'h0BAD_0BAD, 4'hF, 3'b000, "w_unpriv");
        rd(32'h30, 32'h5566_7788, 3'b001, "r_after_unpriv");
        rd(32'h30, 32'h0000_0000, 3'b000, "r_unpriv");
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
